// File: rtl/ssd4_bcd_formatter_pkg.sv
// Shared constants, state encoding and display packing for the 4-digit BCD formatter.
package ssd4_bcd_formatter_pkg;

  localparam int NUM_DIGITS    = 4;
  localparam int NIB_W         = 4;
  localparam int DIGIT_W       = 5;
  localparam int NIB_OFS       = 0;
  localparam int DP_OFS        = 4;
  localparam int BCD_W         = NUM_DIGITS * NIB_W;
  localparam int DISP_W        = NUM_DIGITS * DIGIT_W;
  localparam int MAX_VALUE_DEF = 9999;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Digit i occupies a 5-bit field: nibble in the low four bits, point above it.
  function automatic logic [DISP_W-1:0] pack_display(input logic [BCD_W-1:0]      bcd,
                                                     input logic [NUM_DIGITS-1:0] dp);
    logic [DISP_W-1:0] w;
    w = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w[i*DIGIT_W+NIB_OFS +: NIB_W] = bcd[i*NIB_W +: NIB_W];
      w[i*DIGIT_W+DP_OFS]           = dp[i];
    end
    return w;
  endfunction

endpackage

// File: rtl/ssd4_bcd_formatter_bcd_add3_stage.sv
// Double-dabble correction: every BCD nibble of 5 or more gets +3 before the shift.
module bcd_add3_stage
  import ssd4_bcd_formatter_pkg::*;
(
  input  logic [BCD_W-1:0] bcd_in,
  output logic [BCD_W-1:0] bcd_out
);

  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
    logic [NIB_W-1:0] nib;
    assign nib = bcd_in[d*NIB_W +: NIB_W];
    assign bcd_out[d*NIB_W +: NIB_W] = (nib >= 4'd5) ? nib + 4'd3 : nib;
  end

endmodule

// File: rtl/ssd4_bcd_formatter.sv
// Sequential binary-to-BCD formatter feeding the 4-digit seven-segment scan driver.
//   state    | meaning
//   ST_IDLE  | waiting for START; OUTPUT holds the last result
//   ST_SHIFT | shift-add-3 engine running, one binary bit per clock
module ssd4_bcd_formatter
  import ssd4_bcd_formatter_pkg::*;
#(
  parameter int BIN_WIDTH = 14,
  parameter int MAX_VALUE = MAX_VALUE_DEF
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [BIN_WIDTH-1:0] IN_VALUE,
  input  logic [3:0]           DP_MASK,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 OVERFLOW,
  output logic [19:0]          OUTPUT
);

  if (BIN_WIDTH < 4 || BIN_WIDTH > 14) begin : g_bad_width
    $error("ssd4_bcd_formatter: BIN_WIDTH must be in 4..14");
  end
  if (MAX_VALUE > 9999 || MAX_VALUE > (1 << BIN_WIDTH) - 1) begin : g_bad_max
    $error("ssd4_bcd_formatter: MAX_VALUE exceeds 9999 or 2^BIN_WIDTH-1");
  end

  localparam int                   CNT_W   = $clog2(BIN_WIDTH);
  localparam logic [BIN_WIDTH-1:0] MAX_BIN = BIN_WIDTH'(MAX_VALUE);

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic [BIN_WIDTH-1:0]    bin_sr, bin_nxt;
  logic [BCD_W-1:0]        bcd, bcd_nxt, bcd_corr, bcd_shifted;
  logic [NUM_DIGITS-1:0]   dp_r, dp_nxt;
  logic [DISP_W-1:0]       out_r, out_nxt;
  logic                    ovf_r, ovf_nxt;
  logic                    done_r, done_nxt;

  bcd_add3_stage u_add3 (
    .bcd_in  (bcd),
    .bcd_out (bcd_corr)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      bin_sr <= '0;
      bcd    <= '0;
      dp_r   <= '0;
      out_r  <= '0;
      ovf_r  <= 1'b0;
      done_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      bin_sr <= bin_nxt;
      bcd    <= bcd_nxt;
      dp_r   <= dp_nxt;
      out_r  <= out_nxt;
      ovf_r  <= ovf_nxt;
      done_r <= done_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bin_nxt     = bin_sr;
    bcd_nxt     = bcd;
    dp_nxt      = dp_r;
    out_nxt     = out_r;
    ovf_nxt     = ovf_r;
    done_nxt    = 1'b0;
    bcd_shifted = {bcd_corr[BCD_W-2:0], bin_sr[BIN_WIDTH-1]};

    case (state)
      ST_IDLE: begin
        if (START) begin
          state_nxt = ST_SHIFT;
          cnt_nxt   = CNT_W'(BIN_WIDTH - 1);
          bin_nxt   = (IN_VALUE > MAX_BIN) ? MAX_BIN : IN_VALUE;
          bcd_nxt   = '0;
          dp_nxt    = DP_MASK;
          ovf_nxt   = (IN_VALUE > MAX_BIN);
        end
      end
      ST_SHIFT: begin
        bcd_nxt = bcd_shifted;
        bin_nxt = {bin_sr[BIN_WIDTH-2:0], 1'b0};
        cnt_nxt = cnt - CNT_W'(1);
        // The display word is taken from the post-shift value so it lands with DONE.
        if (cnt == '0) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
          out_nxt   = pack_display(bcd_shifted, dp_r);
          done_nxt  = 1'b1;
        end
      end
    endcase
  end

  assign BUSY     = (state == ST_SHIFT);
  assign DONE     = done_r;
  assign OVERFLOW = ovf_r;
  assign OUTPUT   = out_r;

endmodule

// File: tb/tb_ssd4_bcd_formatter.sv
// Directed self-checking bench for ssd4_bcd_formatter with hand-computed display words.
module tb_ssd4_bcd_formatter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic [13:0] IN_VALUE;
  logic [3:0]  DP_MASK;
  logic        BUSY;
  logic        DONE;
  logic        OVERFLOW;
  logic [19:0] OUTPUT;

  int n_checks = 0;
  int n_errors = 0;

  ssd4_bcd_formatter #(.BIN_WIDTH(14), .MAX_VALUE(9999)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .START    (START),
    .IN_VALUE (IN_VALUE),
    .DP_MASK  (DP_MASK),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .OVERFLOW (OVERFLOW),
    .OUTPUT   (OUTPUT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One conversion: accept, then watch up to 30 edges for DONE. poke_at>0 re-pulses
  // START with a different value that many cycles after accept.
  task automatic run_conv(input string tag, input logic [13:0] val, input logic [3:0] dp,
                          input logic [19:0] exp_out, input logic exp_ovf, input int poke_at);
    int          lat;
    int          nb;
    logic        stable;
    logic [19:0] prev;
    @(negedge CLK);
    START    = 1'b1;
    IN_VALUE = val;
    DP_MASK  = dp;
    prev     = OUTPUT;
    @(posedge CLK);
    #1;
    START  = 1'b0;
    lat    = 0;
    nb     = BUSY ? 1 : 0;
    stable = (OUTPUT === prev);
    for (int i = 1; i <= 30; i++) begin
      @(posedge CLK);
      #1;
      if (i == poke_at) begin
        START    = 1'b1;
        IN_VALUE = 14'd2222;
        DP_MASK  = 4'b1111;
      end else begin
        START = 1'b0;
      end
      if (DONE) begin
        lat = i;
        break;
      end
      if (BUSY) nb++;
      if (OUTPUT !== prev) stable = 1'b0;
    end
    check({tag, " latency"}, lat, 14);
    check({tag, " busy_cycles"}, nb, 14);
    check({tag, " no_intermediate"}, stable, 1);
    check({tag, " busy_at_done"}, BUSY, 0);
    check({tag, " output"}, OUTPUT, exp_out);
    check({tag, " overflow"}, OVERFLOW, exp_ovf);
    @(posedge CLK);
    #1;
    check({tag, " done_one_cycle"}, DONE, 0);
  endtask

  initial begin
    int ndone;
    int d;
    int t [3];
    logic [19:0] exp_seq [3];
    exp_seq[0] = 20'h00001;
    exp_seq[1] = 20'h00002;
    exp_seq[2] = 20'h00003;

    RST      = 1'b1;
    START    = 1'b1;
    IN_VALUE = 14'd1234;
    DP_MASK  = 4'b1111;
    repeat (3) @(posedge CLK);
    #1;
    check("reset busy", BUSY, 0);
    check("reset done", DONE, 0);
    check("reset overflow", OVERFLOW, 0);
    check("reset output", OUTPUT, 20'h00000);
    START = 1'b0;
    RST   = 1'b0;
    @(posedge CLK);
    #1;
    check("idle after reset busy", BUSY, 0);

    run_conv("c1234", 14'd1234, 4'b0000, 20'h08864, 1'b0, 0);
    run_conv("c9999", 14'd9999, 4'b0010, 20'h4A729, 1'b0, 0);
    run_conv("c12000", 14'd12000, 4'b0000, 20'h4A529, 1'b1, 0);
    run_conv("c0", 14'd0, 4'b0000, 20'h00000, 1'b0, 0);
    run_conv("c_ignore", 14'd1111, 4'b0000, 20'h08421, 1'b0, 5);

    ndone = 0;
    repeat (20) begin
      @(posedge CLK);
      #1;
      if (DONE) ndone++;
    end
    check("ignore extra_done", ndone, 0);
    check("ignore output_kept", OUTPUT, 20'h08421);

    // Reset 7 cycles into a conversion of 4321.
    @(negedge CLK);
    START    = 1'b1;
    IN_VALUE = 14'd4321;
    DP_MASK  = 4'b0000;
    @(posedge CLK);
    #1;
    START = 1'b0;
    repeat (7) @(posedge CLK);
    #1;
    check("abort busy_before", BUSY, 1);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    check("abort busy", BUSY, 0);
    check("abort output", OUTPUT, 20'h00000);
    check("abort done", DONE, 0);
    RST   = 1'b0;
    ndone = 0;
    repeat (20) begin
      @(posedge CLK);
      #1;
      if (DONE) ndone++;
    end
    check("abort no_done", ndone, 0);
    run_conv("c4321", 14'd4321, 4'b0000, 20'h20C41, 1'b0, 0);

    // START held high: conversions back to back.
    @(negedge CLK);
    START    = 1'b1;
    IN_VALUE = 14'd1;
    DP_MASK  = 4'b0000;
    d        = 0;
    t        = '{0, 0, 0};
    for (int c = 0; c < 80 && d < 3; c++) begin
      @(posedge CLK);
      #1;
      if (DONE) begin
        check($sformatf("b2b output%0d", d), OUTPUT, exp_seq[d]);
        t[d] = c;
        d++;
        IN_VALUE = 14'(d + 1);
      end
    end
    START = 1'b0;
    check("b2b count", d, 3);
    check("b2b first_latency", t[0], 14);
    check("b2b gap1", t[1] - t[0], 15);
    check("b2b gap2", t[2] - t[1], 15);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
